// File: rtl/hdmi_decode.sv
// hdmi_decode: three-channel TMDS decoder. Each channel searches for control-token alignment
// and may request bitslips; pixel and sync outputs are produced once all three channels are aligned.

module hdmi_decode_chan #(
  parameter int unsigned CTRL_LOCK_CNT  = 8,
  parameter int unsigned SEARCH_TIMEOUT = 1024,
  parameter int unsigned SLIP_WAIT      = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic is_token,
  output logic bitslip,
  output logic locked_c
);
  localparam int unsigned RW   = $clog2(CTRL_LOCK_CNT + 1);
  localparam int unsigned TMAX = (SEARCH_TIMEOUT > SLIP_WAIT) ? SEARCH_TIMEOUT : SLIP_WAIT;
  localparam int unsigned TW   = $clog2(TMAX + 1);
  localparam logic [RW-1:0] RUN_FULL  = RW'(CTRL_LOCK_CNT);
  localparam logic [TW-1:0] TIMER_END = TW'(SEARCH_TIMEOUT - 1);
  localparam logic [TW-1:0] WAIT_END  = TW'(SLIP_WAIT - 1);

  typedef enum logic [1:0] {ST_SEARCH, ST_WAIT, ST_LOCKED} state_t;

  state_t        state_q, state_d;
  logic [RW-1:0] run_q, run_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          slip_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_SEARCH;
      run_q   <= '0;
      timer_q <= '0;
      bitslip <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      timer_q <= timer_d;
      bitslip <= slip_d;
    end
  end

  // Lock qualification is judged on the updated run count, so it wins over a same-cycle timeout.
  always_comb begin
    state_d = state_q;
    slip_d  = 1'b0;
    timer_d = timer_q + TW'(1);
    if (!is_token)
      run_d = '0;
    else if (run_q == RUN_FULL)
      run_d = RUN_FULL;
    else
      run_d = run_q + RW'(1);
    unique case (state_q)
      ST_SEARCH: begin
        if (run_d == RUN_FULL) begin
          state_d = ST_LOCKED;
          timer_d = '0;
        end else if (timer_q == TIMER_END) begin
          state_d = ST_WAIT;
          timer_d = '0;
          run_d   = '0;
          slip_d  = 1'b1;
        end
      end
      ST_WAIT: begin
        run_d = '0;
        if (timer_q == WAIT_END) begin
          state_d = ST_SEARCH;
          timer_d = '0;
        end
      end
      ST_LOCKED: begin
        if (run_d == RUN_FULL) begin
          timer_d = '0;
        end else if (timer_q == TIMER_END) begin
          state_d = ST_SEARCH;
          timer_d = '0;
        end
      end
      default: begin
        state_d = ST_SEARCH;
        timer_d = '0;
        run_d   = '0;
      end
    endcase
    locked_c = (state_d == ST_LOCKED);
  end
endmodule

module hdmi_decode #(
  parameter int unsigned CTRL_LOCK_CNT  = 8,
  parameter int unsigned SEARCH_TIMEOUT = 1024,
  parameter int unsigned SLIP_WAIT      = 4
) (
  input  logic        i_p_clk,
  input  logic        i_resetn,
  input  logic [9:0]  i_tmds_red,
  input  logic [9:0]  i_tmds_green,
  input  logic [9:0]  i_tmds_blue,
  output logic [2:0]  o_bitslip,
  output logic        o_locked,
  output logic [11:0] o_pixel,
  output logic        o_hsync,
  output logic        o_vsync,
  output logic        o_active_area
);
  localparam int unsigned NCH = 3;

  function automatic logic is_ctrl(input logic [9:0] q);
    return (q == 10'b1101010100) || (q == 10'b0010101011) ||
           (q == 10'b0101010100) || (q == 10'b1010101011);
  endfunction

  function automatic logic [1:0] ctrl_code(input logic [9:0] q);
    logic [1:0] c;
    c = 2'b00;
    case (q)
      10'b0010101011: c = 2'b01;
      10'b0101010100: c = 2'b10;
      10'b1010101011: c = 2'b11;
      default:        c = 2'b00;
    endcase
    return c;
  endfunction

  function automatic logic [7:0] tmds_data(input logic [9:0] q);
    logic [7:0] t;
    logic [7:0] d;
    t    = q[9] ? ~q[7:0] : q[7:0];
    d    = '0;
    d[0] = t[0];
    for (int i = 1; i < 8; i++)
      d[i] = q[8] ? (t[i] ^ t[i-1]) : ~(t[i] ^ t[i-1]);
    return d;
  endfunction

  // Index 2 = red, 1 = green, 0 = blue, matching o_bitslip.
  logic [NCH-1:0][9:0] s1_sym;
  logic [NCH-1:0]      tok_c;
  logic [NCH-1:0]      lock_c;
  logic                all_locked_c;
  logic                active_c;
  logic [11:0]         pixel_c;
  logic [1:0]          sync_c;
  logic [7:0]          dec_r_c, dec_g_c, dec_b_c;

  always_ff @(posedge i_p_clk or negedge i_resetn) begin
    if (!i_resetn)
      s1_sym <= '0;
    else
      s1_sym <= {i_tmds_red, i_tmds_green, i_tmds_blue};
  end

  for (genvar ch = 0; ch < NCH; ch++) begin : g_chan
    assign tok_c[ch] = is_ctrl(s1_sym[ch]);
    hdmi_decode_chan #(
      .CTRL_LOCK_CNT (CTRL_LOCK_CNT),
      .SEARCH_TIMEOUT(SEARCH_TIMEOUT),
      .SLIP_WAIT     (SLIP_WAIT)
    ) u_chan (
      .clk     (i_p_clk),
      .rst_n   (i_resetn),
      .is_token(tok_c[ch]),
      .bitslip (o_bitslip[ch]),
      .locked_c(lock_c[ch])
    );
  end

  // Sync holds its last blue-token value through active video.
  always_comb begin
    all_locked_c = &lock_c;
    active_c     = ~|tok_c;
    dec_r_c      = tmds_data(s1_sym[2]);
    dec_g_c      = tmds_data(s1_sym[1]);
    dec_b_c      = tmds_data(s1_sym[0]);
    pixel_c      = '0;
    sync_c       = {o_vsync, o_hsync};
    if (active_c)
      pixel_c = {dec_r_c[7:4], dec_g_c[7:4], dec_b_c[7:4]};
    if (tok_c[0])
      sync_c = ctrl_code(s1_sym[0]);
  end

  // o_locked registers the AND of the channels' next states, so it and the gated outputs move together.
  always_ff @(posedge i_p_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      o_locked      <= 1'b0;
      o_pixel       <= '0;
      o_hsync       <= 1'b0;
      o_vsync       <= 1'b0;
      o_active_area <= 1'b0;
    end else begin
      o_locked <= all_locked_c;
      if (all_locked_c) begin
        o_pixel            <= pixel_c;
        {o_vsync, o_hsync} <= sync_c;
        o_active_area      <= active_c;
      end else begin
        o_pixel       <= '0;
        o_hsync       <= 1'b0;
        o_vsync       <= 1'b0;
        o_active_area <= 1'b0;
      end
    end
  end
endmodule
